// File: rtl/cla_mp_seq_pkg.sv
// Shared constants for the multi-precision CLA sequencer.
package cla_mp_seq_pkg;

  localparam int BYTE_W = 8;

  // FSM encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/CLA_8bit.sv
// 8-bit carry-lookahead adder: every carry is a flat sum-of-products of
// generate/propagate terms rather than a ripple chain.
module CLA_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] w_g;
  logic [7:0] w_p;
  logic [8:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]cin
  always_comb begin
    logic acc;
    logic pp;
    w_c    = '0;
    w_c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      acc = w_g[i];
      pp  = w_p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & w_g[j]);
        pp  = pp & w_p[j];
      end
      w_c[i+1] = acc | (pp & cin);
    end
  end

  assign sum  = w_p ^ w_c[7:0];
  assign cout = w_c[8];

endmodule

// File: rtl/cla_mp_seq.sv
// Multi-precision add/subtract sequencer: one CLA_8bit, one byte per clock,
// LSB first, carry chained through a register. valid/ready on both sides.
module cla_mp_seq
  import cla_mp_seq_pkg::*;
#(
  parameter  int NUM_BYTES = 4,
  localparam int W         = 8 * NUM_BYTES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         sub,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         overflow
);

  localparam int CNT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BYTES - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_sub;
  logic [W-1:0]     r_a_sh;
  logic [W-1:0]     r_b_sh;
  logic [W-1:0]     r_result;
  logic             r_cout;
  logic             r_ovf;

  logic [7:0]       w_a;
  logic [7:0]       w_b_eff;
  logic [7:0]       w_sum;
  logic             w_cout;
  logic             w_ovf;
  logic             w_last;
  logic [W-1:0]     w_res_next;

  // Subtraction is A + ~B + 1: invert B per byte, carry register seeded with 1.
  assign w_a     = r_a_sh[7:0];
  assign w_b_eff = r_b_sh[7:0] ^ {8{r_sub}};
  assign w_last  = (r_cnt == CNT_LAST);
  assign w_ovf   = (w_a[7] == w_b_eff[7]) & (w_sum[7] != w_a[7]);

  CLA_8bit u_cla (
    .a    (w_a),
    .b    (w_b_eff),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Result fills from the top so the LSB byte lands at bit 0 after the last step.
  generate
    if (NUM_BYTES == 1) begin : g_res_one
      assign w_res_next = w_sum;
    end else begin : g_res_multi
      assign w_res_next = {w_sum, r_result[W-1:BYTE_W]};
    end
  endgenerate

  // Sequencer FSM and byte-serial datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_sub    <= 1'b0;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a_sh  <= op_a;
            r_b_sh  <= op_b;
            r_sub   <= sub;
            r_carry <= sub ? 1'b1 : cin;
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_result <= w_res_next;
          r_a_sh   <= r_a_sh >> BYTE_W;
          r_b_sh   <= r_b_sh >> BYTE_W;
          r_carry  <= w_cout;
          if (w_last) begin
            r_cout  <= w_cout;
            r_ovf   <= w_ovf;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;
  assign cout      = r_cout;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_cla_mp_seq.sv
// Self-checking bench for cla_mp_seq (NUM_BYTES=4): directed corner cases,
// backpressure, back-to-back, async reset mid-run, then random traffic
// against a plain-arithmetic reference model.
module tb_cla_mp_seq;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  int n_chk;
  int n_err;

  cla_mp_seq #(.NUM_BYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {overflow, cout, result} from whole-word arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s, input logic ci);
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         ov;
    if (s) begin
      full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      r    = full[W-1:0];
      ov   = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    end else begin
      full = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
      r    = full[W-1:0];
      ov   = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    end
    return {ov, full[W], r};
  endfunction

  // Present a command while in_ready is high; returns after the accept edge.
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic ci);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    chk("in_ready_before_accept", 64'(in_ready), 64'(1));
    op_a = a; op_b = b; sub = s; cin = ci; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("in_ready_after_accept", 64'(in_ready), 64'(0));
  endtask

  // Count edges until out_valid and check latency and outputs.
  task automatic collect(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic ci);
    logic [W+1:0] e;
    int lat;
    e   = model(a, b, s, ci);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, "_valid"},   64'(out_valid), 64'(1));
    chk({tag, "_latency"}, 64'(lat),       64'(NB));
    chk({tag, "_result"},  64'(result),    64'(e[W-1:0]));
    chk({tag, "_cout"},    64'(cout),      64'(e[W]));
    chk({tag, "_ovf"},     64'(overflow),  64'(e[W+1]));
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_out_valid", 64'(out_valid), 64'(0));
    chk("release_in_ready",  64'(in_ready),  64'(1));
  endtask

  task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic s, input logic ci);
    accept(a, b, s, ci);
    collect(tag, a, b, s, ci);
    release_out();
  endtask

  initial begin
    logic [W-1:0] r_sub1;
    logic [W+1:0] e;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;
    logic         rc;
    n_chk = 0; n_err = 0;
    in_valid = 0; op_a = '0; op_b = '0; sub = 0; cin = 0; out_ready = 0;
    rst_n = 1'b0;
    #12;
    chk("rst_in_ready",  64'(in_ready),  64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_result",    64'(result),    64'(0));
    chk("rst_cout",      64'(cout),      64'(0));
    chk("rst_ovf",       64'(overflow),  64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed corners
    op("add_ff_1",   32'h000000FF, 32'h00000001, 1'b0, 1'b0);
    chk("add_ff_1_val", 64'(result), 64'h00000100);
    op("add_wrap",   32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    op("add_ovf",    32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    chk("add_ovf_val", 64'({overflow, result}), 64'({1'b1, 32'h80000000}));
    op("add_cin",    32'h00000000, 32'h00000000, 1'b0, 1'b1);
    chk("add_cin_val", 64'(result), 64'h00000001);
    op("sub_neg",    32'h00000005, 32'h00000007, 1'b1, 1'b0);
    chk("sub_neg_val", 64'({cout, result}), 64'({1'b0, 32'hFFFFFFFE}));
    op("sub_ovf",    32'h80000000, 32'h00000001, 1'b1, 1'b0);
    chk("sub_ovf_val", 64'({overflow, cout, result}), 64'({2'b11, 32'h7FFFFFFF}));

    // cin must not affect subtraction
    op("sub_cin0", 32'h1234ABCD, 32'h0F0F0F0F, 1'b1, 1'b0);
    r_sub1 = result;
    op("sub_cin1", 32'h1234ABCD, 32'h0F0F0F0F, 1'b1, 1'b1);
    chk("sub_cin_same", 64'(result), 64'(r_sub1));

    // Backpressure with an ignored command presented meanwhile
    accept(32'hDEADBEEF, 32'h01020304, 1'b0, 1'b1);
    collect("bp", 32'hDEADBEEF, 32'h01020304, 1'b0, 1'b1);
    e = model(32'hDEADBEEF, 32'h01020304, 1'b0, 1'b1);
    op_a = 32'h11111111; op_b = 32'h22222222; sub = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", 64'({in_ready, out_valid, overflow, cout, result}),
                     64'({1'b0, 1'b1, e[W+1], e[W], e[W-1:0]}));
    end
    in_valid = 1'b0;
    release_out();
    @(posedge clk); #1;
    chk("bp_no_late_accept", 64'(in_ready), 64'(1));

    // Back-to-back: new command held during the release edge
    accept(32'hAAAA5555, 32'h5555AAAB, 1'b0, 1'b0);
    collect("b2b_1", 32'hAAAA5555, 32'h5555AAAB, 1'b0, 1'b0);
    op_a = 32'h00001000; op_b = 32'h00002000; sub = 1'b1; cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b_idle", 64'({in_ready, out_valid}), 64'({1'b1, 1'b0}));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_accepted", 64'(in_ready), 64'(0));
    collect("b2b_2", 32'h00001000, 32'h00002000, 1'b1, 1'b0);
    release_out();

    // Async reset after two byte edges
    accept(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_result",    64'(result),    64'(0));
    chk("mid_rst_in_ready",  64'(in_ready),  64'(1));
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    op("post_rst", 32'h12345678, 32'h11111111, 1'b0, 1'b0);
    chk("post_rst_val", 64'(result), 64'h23456789);

    // Random traffic with random backpressure
    for (int n = 0; n < 40; n++) begin
      ra = $urandom; rb = $urandom;
      if (n % 5 == 0) rb = ~ra;
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      accept(ra, rb, rs, rc);
      collect("rand", ra, rb, rs, rc);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      release_out();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
